// File: rtl/serial_audio_pkg.sv
// Shared serial audio constants and helpers.
// Used by both the encoder and the decoder.
package serial_audio_pkg;

  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  localparam int SLOT_W     = $clog2(SLOT_BITS);
  localparam int POS_W      = $clog2(FRAME_BITS);

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  // Slot offset where the MSB of a word goes out.
  function automatic logic [SLOT_W-1:0] msb_offset(
    input logic i2s
  );
    return i2s ? SLOT_W'(1) : '0;
  endfunction

endpackage

// File: rtl/serial_audio_encoder.sv
// Serial audio encoder: LJ / I2S, one-deep buffer per channel.
// Outputs are registered one cycle behind the frame position.
module serial_audio_encoder
  import serial_audio_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 is_i2s,
  input  logic                 lrclk_polarity,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic                 i_is_left,
  input  logic [SLOT_BITS-1:0] i_audio,
  output logic                 lrclk,
  output logic                 sdout,
  output logic                 is_error
);

  logic [POS_W-1:0]     r_pos;
  logic                 r_i2s;
  logic                 r_pol;
  logic [SLOT_BITS-1:0] r_buf_l;
  logic [SLOT_BITS-1:0] r_buf_r;
  logic                 r_full_l;
  logic                 r_full_r;
  logic [SLOT_BITS-1:0] r_sr;
  logic                 r_lrclk;
  logic                 r_sdout;
  logic                 r_err;

  logic                 w_start;
  logic                 w_i2s;
  logic                 w_pol;
  chan_e                w_chan;
  logic [SLOT_W-1:0]    w_off;
  logic                 w_load;
  logic                 w_full;
  logic [SLOT_BITS-1:0] w_data;
  logic                 w_acc_l;
  logic                 w_acc_r;
  logic                 w_ld_l;
  logic                 w_ld_r;

  // Format is live at p=0 so the new frame uses it immediately.
  assign w_start = (r_pos == '0);
  assign w_i2s   = w_start ? is_i2s : r_i2s;
  assign w_pol   = w_start ? lrclk_polarity : r_pol;
  assign w_chan  = r_pos[POS_W-1] ? CH_RIGHT : CH_LEFT;
  assign w_off   = r_pos[SLOT_W-1:0];
  assign w_load  = (w_off == msb_offset(w_i2s));

  assign w_full  = (w_chan == CH_RIGHT) ? r_full_r : r_full_l;
  assign w_data  = !w_full ? '0 :
                   (w_chan == CH_RIGHT) ? r_buf_r : r_buf_l;

  assign i_ready = i_is_left ? ~r_full_l : ~r_full_r;
  assign w_acc_l = i_valid && i_ready && i_is_left;
  assign w_acc_r = i_valid && i_ready && !i_is_left;
  assign w_ld_l  = w_load && (w_chan == CH_LEFT);
  assign w_ld_r  = w_load && (w_chan == CH_RIGHT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos <= '0;
      r_i2s <= 1'b0;
      r_pol <= 1'b0;
    end else begin
      r_pos <= r_pos + 1'b1;
      if (w_start) begin
        r_i2s <= is_i2s;
        r_pol <= lrclk_polarity;
      end
    end
  end

  // Shift in zeros so an I2S slot after an LJ slot starts clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr    <= '0;
      r_sdout <= 1'b0;
      r_err   <= 1'b0;
      r_lrclk <= 1'b0;
    end else begin
      r_lrclk <= (w_chan == CH_RIGHT) ? ~w_pol : w_pol;
      if (w_load) begin
        r_sdout <= w_data[SLOT_BITS-1];
        r_sr    <= {w_data[SLOT_BITS-2:0], 1'b0};
        r_err   <= ~w_full;
      end else begin
        r_sdout <= r_sr[SLOT_BITS-1];
        r_sr    <= {r_sr[SLOT_BITS-2:0], 1'b0};
        r_err   <= 1'b0;
      end
    end
  end

  // A same-cycle accept wins the flag; the load takes the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_l  <= '0;
      r_full_l <= 1'b0;
    end else if (w_acc_l) begin
      r_buf_l  <= i_audio;
      r_full_l <= 1'b1;
    end else if (w_ld_l) begin
      r_full_l <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_r  <= '0;
      r_full_r <= 1'b0;
    end else if (w_acc_r) begin
      r_buf_r  <= i_audio;
      r_full_r <= 1'b1;
    end else if (w_ld_r) begin
      r_full_r <= 1'b0;
    end
  end

  assign lrclk    = r_lrclk;
  assign sdout    = r_sdout;
  assign is_error = r_err;

endmodule

// File: doc/serial_audio_encoder.md
SERIAL_AUDIO_ENCODER -- requirements
Module: serial_audio_encoder

Interface
REQ-001 SHALL have port clk  input  1  bit clock (sclk rate); all logic on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port is_i2s  input  1  1 = I2S (MSB one bit after lrclk edge), 0 = left-justified.
REQ-004 SHALL have port lrclk_polarity  input  1  lrclk level that marks the left slot.
REQ-005 SHALL have port i_valid  input  1  sample offered.
REQ-006 SHALL have port i_ready  output  1  sample accepted when i_valid && i_ready.
REQ-007 SHALL have port i_is_left  input  1  channel tag of offered sample.
REQ-008 SHALL have port i_audio  input  32  sample, MSB-aligned two's complement; 24-bit sources occupy [31:8].
REQ-009 SHALL have port lrclk  output  1  word clock, registered.
REQ-010 SHALL have port sdout  output  1  serial data, MSB first, registered.
REQ-011 SHALL have port is_error  output  1  one-cycle underrun pulse, registered.

Function
REQ-012 SHALL keep a free-running 6-bit frame position p (0..63): left slot p=0..31, right slot p=32..63; p wraps 63->0.
REQ-013 SHALL drive lrclk = lrclk_polarity for p=0..31 and ~lrclk_polarity for p=32..63, presented one cycle after the position.
REQ-014 SHALL, in left-justified mode, present slot bit 31-k at slot offset k (k=0..31).
REQ-015 SHALL, in I2S mode, present slot bit 31-(k-1) at offset k=1..31 and the previous slot's bit 0 at offset 0.
REQ-016 SHALL sample is_i2s and lrclk_polarity only at p=0; mid-frame changes take effect at the next frame.
REQ-017 SHALL hold one 32-bit buffer plus full flag per channel; i_ready = ~full of the channel selected by i_is_left (no dependence on i_valid).
REQ-018 SHALL on accept write i_audio into the selected channel buffer and set its full flag.
REQ-019 SHALL load the shift register for a slot at its MSB time (offset 0 LJ, offset 1 I2S), taking the channel buffer and clearing its flag.
REQ-020 SHALL, if the channel buffer is empty at load time, serialize 32 zeros for that slot and pulse is_error for exactly one cycle.
REQ-021 SHALL, on accept and load of the same channel in the same cycle, load the old buffer contents (or underrun if empty, no bypass) and keep the new sample buffered with full set.
REQ-022 SHALL give minimum latency from accept to MSB on sdout of one cycle after the next load point of that channel.
REQ-023 SHALL not reorder: samples of one channel are transmitted in acceptance order; left and right buffers are independent.

Reset
REQ-024 SHALL, while reset is high, set p=0, both full flags=0, shift register=0, lrclk=0, sdout=0, is_error=0, i_ready=1.
REQ-025 SHALL, after reset deassertion mid-frame, restart at p=0 with no partial slot emitted; the first slot with empty buffer underruns (REQ-020).

Structure
REQ-026 SHALL take SLOT_BITS=32 and FRAME_BITS=64 from a shared package serial_audio_pkg used by serial_audio_encoder and the existing decoder.
REQ-027 SHALL be a single module with no sub-modules; target 120-250 lines.

Verification
REQ-028 LJ, polarity=1, left=32'hA5000001, right=32'h80000000 preloaded -> lrclk high 32 bits, sdout A5000001 MSB first from offset 0, then 80000000 with lrclk low, is_error never set.
REQ-029 I2S, polarity=0 same data -> lrclk low during left, MSB at offset 1, right LSB 0 appears at next frame offset 0.
REQ-030 No samples after reset -> sdout all zero, is_error pulses once per slot (at p=0 and p=32 LJ).
REQ-031 Left buffer full, second left offered -> i_ready=0 until left load, then accepted; right offer meanwhile accepted.
REQ-032 Left accepted in same cycle as empty-left load -> slot all zero with is_error, sample sent in next left slot.
REQ-033 Toggle is_i2s at p=20 -> current frame unchanged, new format from next p=0; reset asserted at p=40 -> outputs zero, restart at p=0.
